// File: rtl/cam_xclk_seq.sv
// Camera power-up sequencer and programmable XCLK generator.
// Orders cam_pwdn / xclk / cam_rst_n for the sensor and provides a
// runtime-programmable xclk half-period that changes only at falling edges.
module cam_xclk_seq #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_HALF = 25000,
  parameter int unsigned T_PWDN   = 1000,
  parameter int unsigned T_RST    = 1000,
  parameter int unsigned T_SETTLE = 1000,
  parameter int unsigned TMR_W    = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic             cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic [CNT_W-1:0] cfg_rdata,
  input  logic             start,
  input  logic             stop,
  output logic             xclk,
  output logic             xclk_rise,
  output logic             cam_pwdn,
  output logic             cam_rst_n,
  output logic             ready,
  output logic             busy
);

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    PWRUP  = 3'd1,
    CLKON  = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   q;
  logic [CNT_W-1:0]   half_shadow;
  logic [CNT_W-1:0]   half_active;
  logic               div_en;
  logic               div_wrap;

  // Divider runs through the powered states; in STOP only to finish a high phase.
  assign div_en   = (state == CLKON) || (state == SETTLE) || (state == RUN) ||
                    ((state == STOP) && xclk);
  assign div_wrap = (q == half_active - CNT_W'(1));

  // Next-state logic; stop has priority over start and over timed exits.
  always_comb begin
    state_nx = state;
    case (state)
      OFF:    if (start && !stop) state_nx = PWRUP;
      PWRUP:  if (stop) state_nx = STOP;
              else if (timer == TMR_W'(T_PWDN - 1)) state_nx = CLKON;
      CLKON:  if (stop) state_nx = STOP;
              else if (timer == TMR_W'(T_RST - 1)) state_nx = SETTLE;
      SETTLE: if (stop) state_nx = STOP;
              else if (timer == TMR_W'(T_SETTLE - 1)) state_nx = RUN;
      RUN:    if (stop) state_nx = STOP;
      STOP:   if (!xclk) state_nx = OFF;
      default: state_nx = OFF;
    endcase
  end

  // State, sequence timer and pin outputs; pins are registered from the next state
  // so they change in the same cycle the state register does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      timer     <= '0;
      cam_pwdn  <= 1'b1;
      cam_rst_n <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= (state_nx != state) ? '0 : timer + TMR_W'(1);
      cam_pwdn  <= (state_nx == OFF);
      cam_rst_n <= (state_nx == SETTLE) || (state_nx == RUN);
      ready     <= (state_nx == RUN);
      busy      <= (state_nx == PWRUP) || (state_nx == CLKON) ||
                   (state_nx == SETTLE) || (state_nx == STOP);
    end
  end

  // Half-period divider; new HALF is adopted only on a 1->0 toggle while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      q           <= '0;
      xclk        <= 1'b0;
      xclk_rise   <= 1'b0;
      half_active <= CNT_W'(DEF_HALF);
    end else if (!div_en) begin
      q           <= '0;
      xclk        <= 1'b0;
      xclk_rise   <= 1'b0;
      half_active <= half_shadow;
    end else if (div_wrap) begin
      q           <= '0;
      xclk        <= !xclk;
      xclk_rise   <= !xclk;
      if (xclk) half_active <= half_shadow;
    end else begin
      q         <= q + CNT_W'(1);
      xclk_rise <= 1'b0;
    end
  end

  // HALF register; zero would stall the divider so it is stored as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_shadow <= CNT_W'(DEF_HALF);
    end else if (cfg_we && !cfg_addr) begin
      half_shadow <= (cfg_wdata == '0) ? CNT_W'(1) : cfg_wdata;
    end
  end

  // Read mux: HALF or STATUS {ready, busy, state}.
  always_comb begin
    cfg_rdata = '0;
    if (!cfg_addr) cfg_rdata = half_shadow;
    else           cfg_rdata[4:0] = {ready, busy, state};
  end

endmodule
